// File: rtl/pre_addr_generator.sv
// Predecessor-address producer for one Viterbi target state.
// Serially accepts POS_num candidate path scores, tracks the maximum and
// builds a vector with one bit per maximal candidate (ties set several bits).
// It also emits the saturating survivor metric (max + emission score).
//
// Handshake: a candidate is transferred on a rising edge where
// cand_valid && cand_ready. cand_ready is high only in ACCUM, and the
// producer may hold cand_valid low (stall) for any number of cycles.
module pre_addr_generator #(
  parameter int POS_num     = 11,
  parameter int POS_num_bit = 4,
  parameter int p_size      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [p_size-1:0]   emit_score,
  input  logic                cand_valid,
  input  logic [p_size-1:0]   cand_score,
  output logic                cand_ready,
  output logic                busy,
  output logic                done,
  output logic [POS_num-1:0]  pre_addr_out,
  output logic [p_size-1:0]   best_score,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [POS_num_bit-1:0] LAST_IDX = POS_num_bit'(POS_num - 1);
  localparam logic [POS_num-1:0]     BIT0     = POS_num'(1);

  state_t                 state_q, state_d;
  logic [POS_num_bit-1:0] cnt_q, cnt_d;
  logic [p_size-1:0]      max_q, max_d;
  logic [POS_num-1:0]     vec_q, vec_d;
  logic [p_size-1:0]      emit_q, emit_d;
  logic [POS_num-1:0]     pre_addr_q, pre_addr_d;
  logic [p_size-1:0]      best_q, best_d;

  logic [POS_num-1:0]     cand_bit;
  logic [p_size-1:0]      upd_max;
  logic [POS_num-1:0]     upd_vec;
  logic [p_size:0]        sum;
  logic [p_size-1:0]      sat_sum;

  // Candidate update: the first candidate always seeds max and vector,
  // later ones replace on strictly greater and merge on equal.
  always_comb begin
    cand_bit = BIT0 << cnt_q;
    upd_max  = max_q;
    upd_vec  = vec_q;
    if (cnt_q == '0) begin
      upd_max = cand_score;
      upd_vec = cand_bit;
    end else if (cand_score > max_q) begin
      upd_max = cand_score;
      upd_vec = cand_bit;
    end else if (cand_score == max_q) begin
      upd_vec = vec_q | cand_bit;
    end
    // One extra bit catches the carry so the survivor metric saturates.
    sum     = {1'b0, upd_max} + {1'b0, emit_q};
    sat_sum = sum[p_size] ? {p_size{1'b1}} : sum[p_size-1:0];
  end

  // Next-state and next-register logic for the IDLE/ACCUM/DONE controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    vec_d      = vec_q;
    emit_d     = emit_q;
    pre_addr_d = pre_addr_q;
    best_d     = best_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          emit_d  = emit_score;
          cnt_d   = '0;
          max_d   = '0;
          vec_d   = '0;
        end
      end
      ACCUM: begin
        if (cand_valid) begin
          max_d = upd_max;
          vec_d = upd_vec;
          if (cnt_q == LAST_IDX) begin
            // Final candidate: publish results including its own update.
            state_d    = DONE;
            cnt_d      = '0;
            pre_addr_d = upd_vec;
            best_d     = sat_sum;
          end else begin
            cnt_d = cnt_q + POS_num_bit'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so no partial
  // result is ever presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      max_q      <= '0;
      vec_q      <= '0;
      emit_q     <= '0;
      pre_addr_q <= '0;
      best_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      vec_q      <= vec_d;
      emit_q     <= emit_d;
      pre_addr_q <= pre_addr_d;
      best_q     <= best_d;
    end
  end

  // Outputs are decoded only from registers.
  assign cand_ready   = (state_q == ACCUM);
  assign busy         = (state_q == ACCUM) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign pre_addr_out = pre_addr_q;
  assign best_score   = best_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pre_addr_generator.sv
// Bench for pre_addr_generator: directed runs from the test plan plus a few
// random runs, with a scoreboard queue popped on every done pulse.
module tb_pre_addr_generator;

  localparam int N  = 11;
  localparam int NB = 4;
  localparam int W  = 32;

  typedef logic [W-1:0] score_arr_t [N];
  typedef int           stall_arr_t [N];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] emit_score = '0;
  logic         cand_valid = 1'b0;
  logic [W-1:0] cand_score = '0;
  logic         cand_ready;
  logic         busy;
  logic         done;
  logic [N-1:0] pre_addr_out;
  logic [W-1:0] best_score;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  logic [N-1:0] exp_pa_q[$];
  logic [W-1:0] exp_best_q[$];
  logic [31:0]  exp_cyc_q[$];

  pre_addr_generator #(.POS_num(N), .POS_num_bit(NB), .p_size(W)) dut (
    .clk(clk), .rst(rst), .start(start), .emit_score(emit_score),
    .cand_valid(cand_valid), .cand_score(cand_score),
    .cand_ready(cand_ready), .busy(busy), .done(done),
    .pre_addr_out(pre_addr_out), .best_score(best_score),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: maximum over all candidates, then mark every equal one.
  task automatic push_expected(input score_arr_t s, input logic [W-1:0] e, input int done_at);
    logic [W-1:0] m;
    logic [N-1:0] v;
    logic [W:0]   sm;
    m = s[0];
    for (int i = 1; i < N; i++) if (s[i] > m) m = s[i];
    v = '0;
    for (int i = 0; i < N; i++) if (s[i] == m) v[i] = 1'b1;
    sm = {1'b0, m} + {1'b0, e};
    exp_pa_q.push_back(v);
    exp_best_q.push_back(sm[W] ? {W{1'b1}} : sm[W-1:0]);
    exp_cyc_q.push_back(32'(done_at));
  endtask

  // Scoreboard: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_pa_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        check("pre_addr", pre_addr_out, exp_pa_q.pop_front());
        check("best", best_score, exp_best_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // One full target run; stalls before candidate i, optional start poke
  // during candidate 'poke', optional start held in the DONE cycle.
  task automatic run(input score_arr_t s, input logic [W-1:0] e, input stall_arr_t st,
                     input int poke, input bit start_in_done);
    int t;
    int total;
    total = 0;
    for (int i = 0; i < N; i++) total += st[i];
    @(posedge clk); #1;
    t = cyc;
    push_expected(s, e, t + N + 1 + total);
    start = 1'b1;
    emit_score = e;
    @(posedge clk); #1;
    start = 1'b0;
    emit_score = $urandom();
    check("ready_busy_T1", {busy, cand_ready, done}, 3'b110);
    for (int i = 0; i < N; i++) begin
      repeat (st[i]) begin
        cand_valid = 1'b0;
        cand_score = $urandom();
        @(posedge clk); #1;
      end
      cand_valid = 1'b1;
      cand_score = s[i];
      start = (i == poke);
      @(posedge clk); #1;
    end
    cand_valid = 1'b0;
    start = 1'b0;
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_done_ignored", {busy, dbg_state}, 3'b000);
    end else begin
      @(posedge clk); #1;
    end
    check("no_pending_result", exp_pa_q.size(), 0);
    if (exp_pa_q.size() != 0) begin
      exp_pa_q.delete(); exp_best_q.delete(); exp_cyc_q.delete();
    end
  endtask

  task automatic idle_pulses(input logic [N-1:0] pa, input logic [W-1:0] bs);
    repeat (3) begin
      cand_valid = 1'b1;
      cand_score = $urandom();
      @(posedge clk); #1;
    end
    cand_valid = 1'b0;
    check("idle_pa_hold", pre_addr_out, pa);
    check("idle_best_hold", best_score, bs);
    check("idle_flags", {busy, cand_ready, done}, 3'b000);
  endtask

  // Watchdog: bounds the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    score_arr_t s;
    stall_arr_t no_st;
    stall_arr_t st;
    for (int i = 0; i < N; i++) no_st[i] = 0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pa", pre_addr_out, 0);
    check("rst_best", best_score, 0);
    check("rst_flags", {busy, cand_ready, done}, 3'b000);
    check("rst_state", dbg_state, 0);
    idle_pulses('0, '0);

    // Unique maximum at candidate 9.
    s = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90, 32'd100, 32'd15};
    run(s, 32'd5, no_st, -1, 1'b0);
    check("unique_pa_hold", pre_addr_out, 11'h200);
    check("unique_best_hold", best_score, 32'd105);
    idle_pulses(11'h200, 32'd105);

    // Three-way tie; start also held through DONE.
    s = '{32'd7, 32'd3, 32'd7, 32'd0, 32'd7, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    run(s, 32'd0, no_st, -1, 1'b1);
    check("tie_pa_hold", pre_addr_out, 11'h015);

    // All-zero scores.
    for (int i = 0; i < N; i++) s[i] = '0;
    run(s, 32'd0, no_st, -1, 1'b0);
    check("zero_pa_hold", pre_addr_out, 11'h7FF);

    // Saturation with two-cycle stalls after candidates 1 and 6.
    for (int i = 0; i < N; i++) s[i] = 32'(i * 1000 + 1);
    s[3] = 32'hFFFF_FFF0;
    st = no_st;
    st[2] = 2;
    st[7] = 2;
    run(s, 32'h20, st, -1, 1'b0);
    check("sat_best_hold", best_score, 32'hFFFF_FFFF);

    // Reset mid-run after five candidates.
    @(posedge clk); #1;
    start = 1'b1;
    emit_score = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cand_valid = 1'b1;
      cand_score = 32'(i + 50);
      @(posedge clk); #1;
    end
    cand_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_pa", pre_addr_out, 0);
    check("midrst_best", best_score, 0);
    check("midrst_flags", {busy, cand_ready, done, dbg_state}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midrst_idle", {busy, done, dbg_state}, 4'b0);

    // Restart: all ones, emit 2, with an ignored start during ACCUM.
    for (int i = 0; i < N; i++) s[i] = 32'd1;
    run(s, 32'd2, no_st, 4, 1'b0);
    check("restart_pa_hold", pre_addr_out, 11'h7FF);
    check("restart_best_hold", best_score, 32'd3);

    // Random runs with small score ranges so ties are common.
    repeat (4) begin
      for (int i = 0; i < N; i++) begin
        s[i] = 32'($urandom_range(0, 7));
        st[i] = $urandom_range(0, 1);
      end
      run(s, 32'($urandom_range(0, 100)), st, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
